// File: rtl/sel_arb_defs.sv
// Shared definitions for the four-way select arbiter: state encodings and widths.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sel_arb_defs;

  // Number of requesters / select lines, and the index width that addresses them.
  localparam int SEL_W = 4;
  localparam int IDX_W = 2;

  // FSM state encodings. These are plain constants so the codes stay fixed.
  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_GRANT = 2'd1;
  localparam logic [ST_W-1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/sel_arbiter4_decode.sv
// sel_decode2x4: 2-to-4 active-low select decode of {idx, en}.
// Latency: combinational. The caller registers the result.
// Backpressure: none.
//
// Ports:
//   idx    in   2  index of the line to select
//   en     in   1  enable; when low, all select lines are inactive
//   sel_n  out  4  active-low one-hot select, 4'b1111 when disabled
module sel_decode2x4
  import sel_arb_defs::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [SEL_W-1:0] sel_n
);

  always_comb begin
    sel_n = '1;
    if (en) begin
      sel_n[idx] = 1'b0;
    end
  end

endmodule

// File: rtl/sel_arbiter4.sv
// sel_arbiter4: round-robin owner of one shared resource among four requesters,
//   driving the resource's registered active-low chip selects.
// Latency: a request seen in IDLE/GAP is granted on the next edge. A release
//   (done, dropped req or tenure limit) takes effect on the edge that samples it.
// Backpressure: requesters hold req high until they are served. Each tenure is
//   capped at HOLD_MAX cycles and is always followed by one dead cycle.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   req      in   4  level request per requester
//   done     in   4  release pulse; only the current owner's bit is honoured
//   gnt_idx  out  2  index of current/last owner (holds while no grant)
//   gnt_en   out  1  grant valid
//   sel_n    out  4  registered active-low one-hot select of the owner
//   timeout  out  1  one-cycle pulse in GAP when a tenure hit HOLD_MAX
module sel_arbiter4
  import sel_arb_defs::*;
#(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] req,
  input  logic [SEL_W-1:0] done,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_en,
  output logic [SEL_W-1:0] sel_n,
  output logic             timeout
);

  logic [ST_W-1:0]   state_q,    state_d;
  logic [IDX_W-1:0]  gnt_idx_q,  gnt_idx_d;
  logic              gnt_en_q,   gnt_en_d;
  logic [SEL_W-1:0]  sel_n_q,    sel_n_d;
  logic              timeout_q,  timeout_d;
  logic [IDX_W-1:0]  last_q,     last_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic              own_done;
  logic              own_drop;
  logic              hold_end;

  // Round-robin search starting one past the last owner. Iterating from the
  // farthest candidate down to the nearest lets the nearest set bit win.
  // Offset SEL_W wraps to the last owner itself, so a sole requester that was
  // just served is still found.
  function automatic logic [IDX_W:0] rr_pick(input logic [SEL_W-1:0] r,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int i = SEL_W; i >= 1; i--) begin
      cand = ptr + IDX_W'(i);
      if (r[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  assign {pick_vld, pick_idx} = rr_pick(req, last_q);

  // Release causes, only meaningful while in GRANT.
  assign own_done = done[gnt_idx_q];
  assign own_drop = ~req[gnt_idx_q];
  // hold_cnt is 0 in the first tenure cycle, so this fires in cycle HOLD_MAX.
  assign hold_end = (hold_cnt_q == HOLD_W'(HOLD_MAX - 1));

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_en_d   = gnt_en_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    case (state_q)
      // GAP arbitrates exactly like IDLE; it differs only in that it always
      // lasts a single cycle.
      ST_IDLE, ST_GAP: begin
        if (pick_vld) begin
          state_d    = ST_GRANT;
          gnt_idx_d  = pick_idx;
          gnt_en_d   = 1'b1;
          last_d     = pick_idx;
          hold_cnt_d = '0;
        end else begin
          state_d  = ST_IDLE;
          gnt_en_d = 1'b0;
        end
      end

      ST_GRANT: begin
        if (own_done || own_drop || hold_end) begin
          state_d   = ST_GAP;
          gnt_en_d  = 1'b0;
          // An explicit release in the final cycle is not reported as a timeout.
          timeout_d = hold_end && !own_done && !own_drop;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        gnt_en_d = 1'b0;
      end
    endcase
  end

  // Decode on the next-state path so sel_n is registered alongside gnt_en.
  sel_decode2x4 u_sel_decode (
    .idx   (gnt_idx_d),
    .en    (gnt_en_d),
    .sel_n (sel_n_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      gnt_en_q   <= 1'b0;
      sel_n_q    <= '1;
      timeout_q  <= 1'b0;
      last_q     <= IDX_W'(SEL_W - 1);
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_en_q   <= gnt_en_d;
      sel_n_q    <= sel_n_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_idx = gnt_idx_q;
  assign gnt_en  = gnt_en_q;
  assign sel_n   = sel_n_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sel_arbiter4.sv
// Directed bench for sel_arbiter4: each vector drives req/done for one edge and
// queues the hand-computed outputs expected after that edge; a monitor pops and
// compares every cycle, plus immediately after an asynchronous reset assertion.
module tb_sel_arbiter4;

  localparam int HOLD_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [1:0] gnt_idx;
  logic       gnt_en;
  logic [3:0] sel_n;
  logic       timeout;

  always #5 clk = ~clk;

  sel_arbiter4 #(
    .HOLD_MAX (HOLD_MAX),
    .HOLD_W   (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_en  (gnt_en),
    .sel_n   (sel_n),
    .timeout (timeout)
  );

  typedef struct {
    logic       en;
    logic [1:0] idx;
    logic       to;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Drive one cycle of inputs, then queue what must be visible after the edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic en,
                     input logic [1:0] idx, input logic to, input string nm);
    exp_t e;
    req  = r;
    done = d;
    @(posedge clk);
    e.en  = en;
    e.idx = idx;
    e.to  = to;
    e.nm  = nm;
    exp_q.push_back(e);
    #1;
  endtask

  // Assert reset mid-cycle; the reset values must appear before any edge.
  task automatic async_reset(input logic [3:0] r, input string nm);
    exp_t e;
    @(negedge clk);
    #3;
    req   = r;
    done  = 4'b0000;
    e.en  = 1'b0;
    e.idx = 2'd0;
    e.to  = 1'b0;
    e.nm  = nm;
    exp_q.push_back(e);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares at mid-cycle, and right after reset falls.
  exp_t       mon_e;
  logic [3:0] mon_sel;
  logic [3:0] one_hot;
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        mon_e   = exp_q.pop_front();
        one_hot = 4'b0001 << mon_e.idx;
        mon_sel = mon_e.en ? ~one_hot : 4'b1111;
        n_vec++;
        if (gnt_en !== mon_e.en || gnt_idx !== mon_e.idx ||
            sel_n !== mon_sel || timeout !== mon_e.to) begin
          n_bad++;
          $display("FAIL %s: got gnt_en=%0b gnt_idx=%0d sel_n=%b timeout=%0b, want gnt_en=%0b gnt_idx=%0d sel_n=%b timeout=%0b",
                   mon_e.nm, gnt_en, gnt_idx, sel_n, timeout,
                   mon_e.en, mon_e.idx, mon_sel, mon_e.to);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got running, want finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] oh;
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 4'b0000;

    // Reset held with all requests high: no grant ever shows.
    for (int i = 0; i < 3; i++) cyc(4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, "reset_hold");
    rst_n = 1'b1;

    // Fairness: pointer starts at 3, so order is 0,1,2,3,0; each owner
    // releases on its 2nd cycle; other requesters' done bits are ignored.
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      cyc(4'b1111, 4'b0000,     1'b1, 2'(k), 1'b0, "rr_grant");
      cyc(4'b1111, 4'b1111 ^ oh, 1'b1, 2'(k), 1'b0, "rr_other_done");
      cyc(4'b1111, oh,          1'b0, 2'(k), 1'b0, "rr_release");
    end
    cyc(4'b1111, 4'b0000, 1'b1, 2'd0, 1'b0, "rr_wrap");
    cyc(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "rr_req_drop");
    cyc(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "rr_to_idle");

    // Single requester 0: three tenure cycles, done at the third edge.
    cyc(4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0, "single_grant");
    cyc(4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0, "single_hold");
    cyc(4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0, "single_hold");
    cyc(4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0, "single_done");
    cyc(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "single_idle");
    cyc(4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0, "idle_done_ignored");

    // Timeout: req[2] alone for a full tenure, then re-granted after the gap.
    cyc(4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0, "to_grant");
    for (int i = 0; i < HOLD_MAX - 1; i++) cyc(4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0, "to_tenure");
    cyc(4'b0100, 4'b0000, 1'b0, 2'd2, 1'b1, "to_pulse");
    cyc(4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0, "to_regrant");

    // Coincidence: done on the last tenure cycle suppresses timeout.
    for (int i = 0; i < HOLD_MAX - 1; i++) cyc(4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0, "coin_tenure");
    cyc(4'b0100, 4'b0100, 1'b0, 2'd2, 1'b0, "coin_done_last");
    cyc(4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, "coin_idle");

    // Owner 3 ignores done from others; dropping req on the last cycle
    // also suppresses timeout.
    cyc(4'b1000, 4'b0000, 1'b1, 2'd3, 1'b0, "own3_grant");
    cyc(4'b1000, 4'b0010, 1'b1, 2'd3, 1'b0, "own3_done1_ignored");
    cyc(4'b1000, 4'b0111, 1'b1, 2'd3, 1'b0, "own3_others_ignored");
    for (int i = 0; i < HOLD_MAX - 3; i++) cyc(4'b1000, 4'b0000, 1'b1, 2'd3, 1'b0, "own3_tenure");
    cyc(4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0, "own3_drop_last");
    cyc(4'b0000, 4'b1000, 1'b0, 2'd3, 1'b0, "gap_done_ignored");
    cyc(4'b0000, 4'b1000, 1'b0, 2'd3, 1'b0, "idle_done_ignored");

    // Reset mid-tenure of owner 2, then pointer restarts at 3 -> index 0 first.
    cyc(4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0, "rst_own2");
    cyc(4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0, "rst_own2_hold");
    async_reset(4'b1001, "rst_async");
    cyc(4'b1001, 4'b0000, 1'b0, 2'd0, 1'b0, "rst_held");
    rst_n = 1'b1;
    cyc(4'b1001, 4'b0000, 1'b1, 2'd0, 1'b0, "rst_ptr_grant0");
    cyc(4'b1001, 4'b0001, 1'b0, 2'd0, 1'b0, "rst_done0");
    cyc(4'b1001, 4'b0000, 1'b1, 2'd3, 1'b0, "rst_next3");
    cyc(4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0, "rst_drop3");
    cyc(4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0, "end_idle");

    // Every queued expectation must have been consumed by the monitor.
    repeat (3) @(negedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sel_arbiter4.md
# sel_arbiter4

Round-robin arbiter that shares one downstream resource among four requesters and drives the 2-to-4 select decode for that resource. It replaces static wiring of the decoder's `a`/`b`/`en` inputs with a sequenced grant: one requester owns the resource at a time, tenure is bounded, and a one-cycle turnaround gap separates grants. Active-low select lines are produced registered, so the resource sees glitch-free chip selects.

## Interface
- `HOLD_MAX`, 15: maximum tenure in cycles per grant (legal range 1..2^HOLD_W-1).
- `HOLD_W`, 4: width of the tenure counter.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per requester; level, held while wanting or using the resource.
- `done`  in  4  release pulse per requester; only the bit of the current owner is honoured.
- `gnt_idx`  out  2  index of the current owner (decoder `{b,a}` equivalent).
- `gnt_en`  out  1  grant valid (decoder `en` equivalent).
- `sel_n`  out  4  active-low one-hot select; `sel_n[gnt_idx]`=0 when `gnt_en`=1, else 4'b1111.
- `timeout`  out  1  one-cycle pulse when a tenure is ended by `HOLD_MAX`.

## Operation
- States: IDLE, GRANT, GAP.
- Reset state: IDLE, `gnt_en`=0, `gnt_idx`=0, `sel_n`=4'b1111, `timeout`=0, priority pointer `last`=3, `hold_cnt`=0.
- IDLE: if `req`≠0, select the first set bit searching `last+1, last+2, …` mod 4, then go to GRANT. Load `gnt_idx`, set `gnt_en`=1, set `last`=selected index, clear `hold_cnt`. If `req`=0, stay in IDLE.
- GRANT: `hold_cnt` increments each cycle. Release when any of these hold:
  - `done[gnt_idx]`=1;
  - `req[gnt_idx]`=0;
  - `hold_cnt`=HOLD_MAX-1 (timeout).
- On release: go to GAP with `gnt_en`=0 and `sel_n`=4'b1111. `timeout`=1 during GAP only if the release cause was timeout alone.
- Release priority: `done` or a dropped `req` beats timeout. If any of them coincides with the last tenure cycle, `timeout` stays 0.
- `done` bits of non-owners are ignored. `done` asserted in IDLE or GAP is ignored.
- GAP: lasts exactly one cycle. Arbitrates like IDLE with the updated `last`:
  - any request → GRANT next cycle;
  - no request → IDLE.
- A sole continuing requester that timed out is re-granted after the single GAP cycle.
- `gnt_idx` holds its last value in GAP and IDLE. Only `gnt_en`/`sel_n` indicate validity.
- Reset mid-tenure: all outputs and state return to their reset values immediately (asynchronous). No GAP cycle is produced.

## Timing
- All outputs are registered. `sel_n` is the registered decode of next-state `{gnt_idx, gnt_en}`, so it changes on the same edge as `gnt_en`.
- Grant latency: `req` first sampled high in IDLE at edge N → `gnt_en`=1 and `sel_n` valid after edge N.
- Release latency: `done` sampled at edge M → `gnt_en`=0 after edge M.
- Minimum gap between tenures: exactly 1 cycle with `gnt_en`=0.
- Maximum tenure: HOLD_MAX cycles with `gnt_en`=1. HOLD_MAX=1 gives single-cycle tenures.
- Worst-case wait for a continuously requesting input: 3×(HOLD_MAX+1) cycles.

## Structure
- Shared package/include `sel_arb_defs`: state encodings (IDLE=2'd0, GRANT=2'd1, GAP=2'd2), select width 4, index width 2.
- One sub-module, `sel_decode2x4`: combinational `{idx[1:0], en}` → active-low `sel_n[3:0]`, instantiated on the next-state path before the output register.
- The round-robin search is a function/local block inside `sel_arbiter4`. It is not a separate module.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `req`=4'b1111 → `sel_n`=4'b1111, `gnt_en`=0, `timeout`=0 throughout.
- Single requester: `req`=4'b0001 sampled at edge 0 → after edge 0 `gnt_idx`=0, `sel_n`=4'b1110. `done[0]` at edge 3 → after edge 3 `sel_n`=4'b1111. Then IDLE once `req` drops.
- Fairness: `req`=4'b1111 constant, owner pulses `done` on its 2nd cycle → grant order 0,1,2,3,0, each tenure 2 cycles, 1-cycle gaps.
- Timeout: only `req[2]` held, no `done`, HOLD_MAX=15 → `gnt_en` high 15 cycles, `timeout`=1 for the GAP cycle, re-grant to index 2 in the next cycle.
- Coincidence: `done[owner]` on the 15th tenure cycle → release with `timeout`=0. `done[1]` while index 3 owns → ignored.
- Reset mid-tenure: assert `rst_n`=0 while index 2 owns → `sel_n`=4'b1111 immediately. Release reset with `req`=4'b1001 → grant goes to index 0 (pointer reset to 3).
